// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register-file write-port arbiter with power-on zero sweep
// Round-robin grants requesters onto a single registered write port once the initial sweep completes.
module rf_write_arbiter #(
    parameter int N    = 5,
    parameter int NREQ = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              we3,
    output logic [N-1:0]      wa3,
    output logic [31:0]       wd3,
    output logic              init_done
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t        r_state;
    logic [N-1:0]  r_cnt;
    logic [PW-1:0] r_ptr;

    logic          w_found;
    logic [PW-1:0] w_gidx;
    logic [PW-1:0] w_ptr_next;
    logic [N-1:0]  w_sel_addr;
    logic [31:0]   w_sel_data;

    // Search starts at the round-robin pointer; the first valid requester wins.
    always_comb begin
        int j;
        j          = 0;
        req_ready  = '0;
        w_found    = 1'b0;
        w_gidx     = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        if (r_state == ST_RUN && !clear_req) begin
            for (int k = 0; k < NREQ; k++) begin
                j = int'(r_ptr) + k;
                if (j >= NREQ) begin
                    j = j - NREQ;
                end
                if (!w_found && req_valid[j]) begin
                    w_found      = 1'b1;
                    w_gidx       = PW'(j);
                    req_ready[j] = 1'b1;
                    w_sel_addr   = req_addr[j*N +: N];
                    w_sel_data   = req_data[j*32 +: 32];
                end
            end
        end
    end

    assign w_ptr_next = (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + PW'(1);
    assign init_done  = (r_state == ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_cnt   <= N'(1);
            r_ptr   <= '0;
            we3     <= 1'b0;
            wa3     <= '0;
            wd3     <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    we3 <= 1'b1;
                    wd3 <= '0;
                    // A clear during the sweep behaves as if the counter were already back at 1.
                    if (clear_req) begin
                        wa3   <= N'(1);
                        r_cnt <= N'(2);
                    end else begin
                        wa3   <= r_cnt;
                        r_cnt <= r_cnt + N'(1);
                        if (r_cnt == {N{1'b1}}) begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        we3     <= 1'b0;
                        r_cnt   <= N'(1);
                        r_state <= ST_INIT;
                    end else if (w_found) begin
                        r_ptr <= w_ptr_next;
                        // Address 0 is hard-wired in the register file: accept and discard.
                        if (w_sel_addr != '0) begin
                            we3 <= 1'b1;
                            wa3 <= w_sel_addr;
                            wd3 <= w_sel_data;
                        end else begin
                            we3 <= 1'b0;
                        end
                    end else begin
                        we3 <= 1'b0;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;
    localparam int N    = 5;
    localparam int NREQ = 3;
    localparam int TOP  = (1 << N) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear_req;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_addr;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              we3;
    logic [N-1:0]      wa3;
    logic [31:0]       wd3;
    logic              init_done;

    rf_write_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .we3(we3), .wa3(wa3), .wd3(wd3),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: sweep position, mode and rotation pointer as plain integers.
    bit m_run;
    int m_next;
    int m_ptr;
    bit m_we;
    int m_wa;
    int m_wd;

    typedef struct {
        logic [NREQ-1:0]    v;
        logic [NREQ*N-1:0]  a;
        logic [NREQ*32-1:0] d;
        logic [NREQ-1:0]    rdy;
        logic               we;
        logic [N-1:0]       wa;
        logic [31:0]        wd;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (!m_run || clear_req) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_run = 0; m_next = 1; m_ptr = 0; m_we = 0; m_wa = 0; m_wd = 0;
    endtask

    task automatic model_edge(input int g);
        int a;
        if (!m_run) begin
            m_we = 1; m_wd = 0;
            if (clear_req) begin
                m_wa = 1; m_next = 2;
            end else begin
                m_wa = m_next;
                if (m_next == TOP) m_run = 1;
                m_next++;
            end
        end else if (clear_req) begin
            m_run = 0; m_next = 1; m_we = 0;
        end else if (g >= 0) begin
            a = int'(req_addr[g*N +: N]);
            if (a != 0) begin
                m_we = 1; m_wa = a; m_wd = int'(req_data[g*32 +: 32]);
            end else begin
                m_we = 0;
            end
            m_ptr = (g + 1) % NREQ;
        end else begin
            m_we = 0;
        end
    endtask

    // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
    task automatic cycle();
        int g;
        logic [NREQ-1:0] er;
        #2;
        g  = model_grant();
        er = (g >= 0) ? NREQ'(1 << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(er));
        @(posedge clk);
        #1;
        model_edge(g);
        chk("we3", 32'(we3), 32'(m_we));
        chk("wa3", 32'(wa3), 32'(m_wa));
        chk("wd3", 32'(wd3), 32'(m_wd));
        chk("init_done", 32'(init_done), 32'(m_run));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_we3"}, 32'(we3), 0);
        chk({nm, "_wa3"}, 32'(wa3), 0);
        chk({nm, "_wd3"}, wd3, 0);
        chk({nm, "_init_done"}, 32'(init_done), 0);
        chk({nm, "_req_ready"}, 32'(req_ready), 0);
    endtask

    initial begin
        reset = 1'b1; clear_req = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        model_reset();
        @(posedge clk); #1;
        chk_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < TOP; i++) cycle();
        chk("sweep_end_wa3", 32'(wa3), 32'(TOP));
        chk("sweep_end_done", 32'(init_done), 1);
        cycle();
        chk("run_idle_we3", 32'(we3), 0);

        tbl[0] = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'hC2, 32'hB1, 32'hA0}, 3'b001, 1'b1, 5'd1, 32'hA0};
        tbl[1] = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'hC2, 32'hB1, 32'hA0}, 3'b010, 1'b1, 5'd2, 32'hB1};
        tbl[2] = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'hC2, 32'hB1, 32'hA0}, 3'b100, 1'b1, 5'd3, 32'hC2};
        tbl[3] = tbl[0];
        tbl[4] = tbl[1];
        tbl[5] = tbl[2];
        tbl[6] = '{3'b100, {5'd5, 5'd0, 5'd0}, {32'hDEADBEEF, 64'h0}, 3'b100, 1'b1, 5'd5, 32'hDEADBEEF};
        tbl[7] = '{3'b001, {5'd5, 5'd0, 5'd0}, {32'hDEADBEEF, 64'h0}, 3'b001, 1'b0, 5'd5, 32'hDEADBEEF};
        tbl[8] = '{3'b011, {5'd0, 5'd8, 5'd7}, {32'h0, 32'h88, 32'h77}, 3'b010, 1'b1, 5'd8, 32'h88};
        tbl[9] = '{3'b000, {5'd0, 5'd8, 5'd7}, {32'h0, 32'h88, 32'h77}, 3'b000, 1'b0, 5'd8, 32'h88};
        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].v; req_addr = tbl[i].a; req_data = tbl[i].d;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            cycle();
            chk($sformatf("tbl%0d_we3", i), 32'(we3), 32'(tbl[i].we));
            chk($sformatf("tbl%0d_wa3", i), 32'(wa3), 32'(tbl[i].wa));
            chk($sformatf("tbl%0d_wd3", i), wd3, tbl[i].wd);
        end

        // Clear in RUN with pending requests: no grant, then a full sweep ignoring requests.
        req_valid = 3'b011; clear_req = 1'b1;
        #1;
        chk("clear_run_ready", 32'(req_ready), 0);
        cycle();
        chk("clear_run_done", 32'(init_done), 0);
        clear_req = 1'b0; req_valid = 3'b111;
        cycle();
        chk("clear_first_wa3", 32'(wa3), 1);
        for (int i = 1; i < TOP; i++) cycle();
        chk("clear_sweep_done", 32'(init_done), 1);

        // Clear again, run part of the sweep, then clear inside INIT to restart it.
        clear_req = 1'b1; cycle();
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        clear_req = 1'b1; cycle();
        chk("init_clear_wa3", 32'(wa3), 1);
        clear_req = 1'b0;
        cycle();
        chk("init_clear_next", 32'(wa3), 2);
        for (int i = 0; i < 15; i++) cycle();
        chk("pre_reset_wa3", 32'(wa3), 17);

        // Asynchronous reset mid-sweep.
        #2 reset = 1'b1;
        #1;
        chk_zero("mid_reset");
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        cycle();
        chk("restart_wa3", 32'(wa3), 1);
        for (int i = 1; i < TOP; i++) cycle();

        for (int i = 0; i < 400; i++) begin
            req_valid = NREQ'($urandom);
            for (int r = 0; r < NREQ; r++) begin
                req_addr[r*N +: N]   = N'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, TOP));
                req_data[r*32 +: 32] = $urandom;
            end
            clear_req = ($urandom_range(0, 59) == 0);
            cycle();
        end
        clear_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter N, default 5, meaning register-file address width (2**N entries).
REQ-002 SHALL have parameter NREQ, default 3, meaning number of write requesters (2..8).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clear_req  input  1  single-cycle request to re-zero the register file.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester write request, bit i = requester i.
REQ-007 SHALL have port req_addr  input  NREQ*N  requester i address in bits [i*N +: N].
REQ-008 SHALL have port req_data  input  NREQ*32  requester i data in bits [i*32 +: 32].
REQ-009 SHALL have port req_ready  output  NREQ  one-hot (or zero) grant, combinational.
REQ-010 SHALL have port we3  output  1  registered write enable to register-file write port.
REQ-011 SHALL have port wa3  output  N  registered write address.
REQ-012 SHALL have port wd3  output  32  registered write data.
REQ-013 SHALL have port init_done  output  1  high when state is RUN.

Function
REQ-014 SHALL implement states INIT and RUN plus an N-bit sweep counter cnt and a round-robin pointer ptr (0..NREQ-1).
REQ-015 In INIT, each clock edge SHALL load we3=1, wa3=cnt, wd3=0, then increment cnt.
REQ-016 INIT SHALL sweep cnt from 1 to 2**N-1 (address 0 never written), then transition to RUN on the edge that loads wa3=2**N-1.
REQ-017 In INIT, req_ready SHALL be all zero.
REQ-018 In RUN, req_ready SHALL assert the single bit of the first valid requester searching ptr, ptr+1, ... wrapping modulo NREQ; all zero if no req_valid bit is set.
REQ-019 A transfer SHALL occur when req_valid[i] && req_ready[i]; at most one per cycle.
REQ-020 On a transfer from requester i with nonzero address, the next edge SHALL load we3=1, wa3=req_addr[i], wd3=req_data[i] (one-cycle latency).
REQ-021 On a transfer with address 0, the request SHALL be accepted and dropped: we3 loads 0.
REQ-022 On any transfer from requester i, ptr SHALL become (i+1) mod NREQ; with no transfer, ptr SHALL hold.
REQ-023 In RUN with no transfer, we3 SHALL load 0; wa3/wd3 SHALL hold their previous values.
REQ-024 clear_req high in RUN SHALL force req_ready to zero that cycle, set cnt=1, and enter INIT on the next edge; no transfer occurs that cycle.
REQ-025 clear_req in INIT SHALL restart the sweep: cnt reloads 1 on that edge, and the write loaded on that edge is wa3=1.
REQ-026 req_valid deasserted by a requester before being granted SHALL be permitted; no request is latched inside the block.
REQ-027 init_done SHALL be combinationally derived from state (RUN=1).

Reset
REQ-028 Asserting reset SHALL immediately force state=INIT, cnt=1, ptr=0, we3=0, wa3=0, wd3=0, init_done=0, req_ready=0.
REQ-029 The first write (wa3=1) SHALL appear after the first rising edge with reset deasserted.
REQ-030 Reset asserted mid-sweep or mid-RUN SHALL abandon any in-flight write; we3 drops to 0 asynchronously.

Verification
REQ-031 Reset release, N=5, no requests -> we3=1 for 31 consecutive cycles with wa3=1..31, wd3=0; then init_done=1, we3=0.
REQ-032 RUN, all three req_valid held high, ptr=0 -> grants 0,1,2,0,1,2; we3/wa3/wd3 follow each grant by one cycle.
REQ-033 RUN, only requester 2 valid with addr 0x05 data 0xDEADBEEF -> req_ready=3'b100, next cycle we3=1, wa3=5, wd3=0xDEADBEEF; ptr becomes 0.
REQ-034 RUN, requester 0 valid with addr 0 -> req_ready[0]=1, next cycle we3=0, ptr=1.
REQ-035 RUN, clear_req and req_valid=3'b011 same cycle -> req_ready=0, next edge enters INIT, sweep wa3=1..31 with all req_ready=0.
REQ-036 Reset pulsed while wa3=17 during INIT -> outputs zero immediately, sweep restarts at wa3=1 after release.
